// File: rtl/bomb_sched_pkg.sv
// Shared tile codes, map geometry and state encodings for the bomb scheduler.
package bomb_sched_pkg;

  localparam logic [2:0] BRICK     = 3'b010;
  localparam logic [2:0] STEEL     = 3'b001;
  localparam logic [2:0] EMPTY     = 3'b000;
  localparam logic [9:0] MAP_COLS  = 10'd20;
  localparam logic [9:0] TILE      = 10'd32;
  localparam logic [9:0] TILE_IDLE = 10'h3FF;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WAITMAP, S_SCAN, S_BLAST} slot_state_e;
  typedef enum logic [1:0] {G_NONE, G_P1, G_P2} gnt_e;

  // Arm order: up, down, left, right.
  function automatic logic [9:0] arm_tile(input logic [9:0] centre, input logic [1:0] arm);
    case (arm)
      2'd0:    arm_tile = centre - MAP_COLS;
      2'd1:    arm_tile = centre + MAP_COLS;
      2'd2:    arm_tile = centre - 10'd1;
      default: arm_tile = centre + 10'd1;
    endcase
  endfunction

endpackage

// File: rtl/bomb_sched_slot.sv
// Per-player bomb slot: drop edge detection, tile latch, fuse and blast counters.
module bomb_slot
  import bomb_sched_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES  = 120,
  parameter int unsigned BLAST_FRAMES = 30
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       paused_i,
  input  logic       drop_i,
  input  logic [9:0] user_x_i,
  input  logic [9:0] user_y_i,
  input  logic       grant_i,
  input  logic       scan_done_i,
  output logic       req_o,
  output logic       vis_o,
  output logic       blast_o,
  output logic [9:0] tile_o,
  output logic [9:0] bomb_x_o,
  output logic [9:0] bomb_y_o
);

  localparam int unsigned CW = 16;

  slot_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_prev_q;
  logic [9:0]    tile_q, tile_d, bx_q, bx_d, by_q, by_d;
  logic [9:0]    xsum, ysum, row, col;

  assign xsum = user_x_i + 10'd10;
  assign ysum = user_y_i + 10'd13;
  assign row  = {5'b0, ysum[9:5]};
  assign col  = {5'b0, xsum[9:5]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drop_prev_q <= 1'b0;
      tile_q      <= '0;
      bx_q        <= '0;
      by_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_prev_q <= drop_i;
      tile_q      <= tile_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    bx_d    = bx_q;
    by_d    = by_q;
    case (state_q)
      S_IDLE: begin
        if (drop_i && !drop_prev_q && !paused_i) begin
          state_d = S_ARMED;
          cnt_d   = CW'(FUSE_FRAMES - 1);
          tile_d  = row * MAP_COLS + col;
          bx_d    = col * TILE;
          by_d    = row * TILE;
        end
      end
      S_ARMED: begin
        if (!paused_i) begin
          if (cnt_q == '0) state_d = S_WAITMAP;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_WAITMAP: if (grant_i) state_d = S_SCAN;
      S_SCAN: begin
        if (scan_done_i) begin
          state_d = S_BLAST;
          cnt_d   = CW'(BLAST_FRAMES - 1);
        end
      end
      S_BLAST: begin
        if (!paused_i) begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requests are withheld while paused so a waiting slot holds in WAITMAP.
  assign req_o    = (state_q == S_WAITMAP) && !paused_i;
  assign vis_o    = (state_q == S_ARMED);
  assign blast_o  = (state_q == S_BLAST);
  assign tile_o   = tile_q;
  assign bomb_x_o = bx_q;
  assign bomb_y_o = by_q;

endmodule

// File: rtl/bomb_sched.sv
// Two-player bomb scheduler: round-robin map arbitration, arm scan sequencer, lethal tile outputs.
module bomb_sched #(
  parameter int unsigned FUSE_FRAMES  = 120,
  parameter int unsigned BLAST_FRAMES = 30,
  parameter logic [9:0]  TILE_IDLE    = bomb_sched_pkg::TILE_IDLE
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic [4:0]      allow,
  input  logic            bomb_drop1,
  input  logic            bomb_drop2,
  input  logic [9:0]      user1X,
  input  logic [9:0]      user1Y,
  input  logic [9:0]      user2X,
  input  logic [9:0]      user2Y,
  output logic [9:0]      map_rdaddr,
  input  logic [3:0]      map_rddata,
  output logic [9:0]      map_wraddr,
  output logic [3:0]      map_wrdata,
  output logic            map_wren,
  output logic [9:0]      bomb1X,
  output logic [9:0]      bomb1Y,
  output logic [9:0]      bomb2X,
  output logic [9:0]      bomb2Y,
  output logic [9:0]      bomb1XS,
  output logic [9:0]      bomb1YS,
  output logic [9:0]      bomb2XS,
  output logic [9:0]      bomb2YS,
  output logic            bomb1_vis,
  output logic            bomb2_vis,
  output logic [9:0][9:0] die_addr
);
  import bomb_sched_pkg::*;

  logic            paused;
  logic [1:0]      req, grant, done, blast;
  logic [1:0][9:0] tile;
  gnt_e            gnt_q, gnt_d, last_q, last_d;
  logic [2:0]      step_q, step_d;
  logic [1:0][3:0] leth_q, leth_d;
  logic            cur;
  logic [9:0]      arm;

  assign paused = (allow == 5'b00000) || (allow == 5'b00001) || (allow == 5'b11111);

  assign bomb1XS = TILE;
  assign bomb1YS = TILE;
  assign bomb2XS = TILE;
  assign bomb2YS = TILE;

  bomb_slot #(.FUSE_FRAMES(FUSE_FRAMES), .BLAST_FRAMES(BLAST_FRAMES)) u_slot1 (
    .clk_i(frame_clk), .rst_i(Reset), .paused_i(paused), .drop_i(bomb_drop1),
    .user_x_i(user1X), .user_y_i(user1Y), .grant_i(grant[0]), .scan_done_i(done[0]),
    .req_o(req[0]), .vis_o(bomb1_vis), .blast_o(blast[0]), .tile_o(tile[0]),
    .bomb_x_o(bomb1X), .bomb_y_o(bomb1Y)
  );

  bomb_slot #(.FUSE_FRAMES(FUSE_FRAMES), .BLAST_FRAMES(BLAST_FRAMES)) u_slot2 (
    .clk_i(frame_clk), .rst_i(Reset), .paused_i(paused), .drop_i(bomb_drop2),
    .user_x_i(user2X), .user_y_i(user2Y), .grant_i(grant[1]), .scan_done_i(done[1]),
    .req_o(req[1]), .vis_o(bomb2_vis), .blast_o(blast[1]), .tile_o(tile[1]),
    .bomb_x_o(bomb2X), .bomb_y_o(bomb2Y)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      gnt_q  <= G_NONE;
      last_q <= G_P2;
      step_q <= '0;
      leth_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
      step_q <= step_d;
      leth_q <= leth_d;
    end
  end

  always_comb begin
    gnt_d      = gnt_q;
    last_d     = last_q;
    step_d     = step_q;
    leth_d     = leth_q;
    grant      = '0;
    done       = '0;
    map_rdaddr = '0;
    map_wraddr = '0;
    map_wrdata = '0;
    map_wren   = 1'b0;
    cur        = (gnt_q == G_P2);
    arm        = arm_tile(tile[cur], step_q[2:1]);
    // Even steps present the arm address; odd steps see its data one cycle later.
    if (gnt_q != G_NONE) begin
      map_rdaddr = arm;
      if (step_q[0]) begin
        leth_d[cur][step_q[2:1]] = (map_rddata != {1'b0, STEEL});
        if (map_rddata == {1'b0, BRICK}) begin
          map_wren   = 1'b1;
          map_wraddr = arm;
          map_wrdata = {1'b0, EMPTY};
        end
      end
      step_d = step_q + 3'd1;
      if (step_q == 3'd7) begin
        done[cur] = 1'b1;
        gnt_d     = G_NONE;
      end
    end
    // Re-arbitrate on the last scan step so a waiting slot starts back-to-back.
    if ((gnt_q == G_NONE) || (step_q == 3'd7)) begin
      if (req[0] && (!req[1] || (last_q == G_P2))) begin
        grant[0] = 1'b1;
        gnt_d    = G_P1;
        last_d   = G_P1;
        step_d   = '0;
      end else if (req[1]) begin
        grant[1] = 1'b1;
        gnt_d    = G_P2;
        last_d   = G_P2;
        step_d   = '0;
      end
    end
  end

  always_comb begin
    die_addr = {10{TILE_IDLE}};
    for (int unsigned p = 0; p < 2; p++) begin
      if (blast[p]) begin
        die_addr[5*p] = tile[p];
        for (int unsigned k = 0; k < 4; k++) begin
          if (leth_q[p][k]) die_addr[5*p + 1 + k] = arm_tile(tile[p], 2'(k));
        end
      end
    end
  end

endmodule

// File: tb/tb_bomb_sched.sv
// Directed self-checking bench for bomb_sched with a 1-cycle-latency map model.
module tb_bomb_sched;

  logic            frame_clk = 1'b0;
  logic            Reset;
  logic [4:0]      allow;
  logic            bomb_drop1, bomb_drop2;
  logic [9:0]      user1X, user1Y, user2X, user2Y;
  logic [9:0]      map_rdaddr, map_wraddr;
  logic [3:0]      map_rddata, map_wrdata;
  logic            map_wren;
  logic [9:0]      bomb1X, bomb1Y, bomb2X, bomb2Y;
  logic [9:0]      bomb1XS, bomb1YS, bomb2XS, bomb2YS;
  logic            bomb1_vis, bomb2_vis;
  logic [9:0][9:0] die_addr;

  bit   [3:0] mem [1024];
  logic       poke_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [3:0] poke_data = '0;
  int         wr_cnt = 0;
  logic [9:0] wr_addr_last = '0;
  logic [3:0] wr_data_last = '0;

  int total = 0;
  int bad   = 0;

  always #5 frame_clk = ~frame_clk;

  bomb_sched #(.FUSE_FRAMES(120), .BLAST_FRAMES(30), .TILE_IDLE(10'h3FF)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .allow(allow),
    .bomb_drop1(bomb_drop1), .bomb_drop2(bomb_drop2),
    .user1X(user1X), .user1Y(user1Y), .user2X(user2X), .user2Y(user2Y),
    .map_rdaddr(map_rdaddr), .map_rddata(map_rddata),
    .map_wraddr(map_wraddr), .map_wrdata(map_wrdata), .map_wren(map_wren),
    .bomb1X(bomb1X), .bomb1Y(bomb1Y), .bomb2X(bomb2X), .bomb2Y(bomb2Y),
    .bomb1XS(bomb1XS), .bomb1YS(bomb1YS), .bomb2XS(bomb2XS), .bomb2YS(bomb2YS),
    .bomb1_vis(bomb1_vis), .bomb2_vis(bomb2_vis), .die_addr(die_addr)
  );

  always @(posedge frame_clk) begin
    map_rddata <= mem[map_rdaddr];
    if (poke_en) mem[poke_addr] <= poke_data;
    if (map_wren) begin
      mem[map_wraddr] <= map_wrdata;
      wr_cnt          <= wr_cnt + 1;
      wr_addr_last    <= map_wraddr;
      wr_data_last    <= map_wrdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic poke(input logic [9:0] a, input logic [3:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick(1);
    poke_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; allow = 5'b00010; bomb_drop1 = 1'b0; bomb_drop2 = 1'b0;
    user1X = 10'd39; user1Y = 10'd35; user2X = 10'd103; user2Y = 10'd99;
    tick(2);
    chk("rst_vis1", bomb1_vis, 0);
    chk("rst_vis2", bomb2_vis, 0);
    chk("rst_wren", map_wren, 0);
    chk("rst_rdaddr", map_rdaddr, 0);
    chk("rst_bomb1X", bomb1X, 0);
    chk("rst_bomb1XS", bomb1XS, 32);
    chk("rst_die0", die_addr[0], 10'h3FF);
    chk("rst_die9", die_addr[9], 10'h3FF);
    Reset = 1'b0;
    tick(1);
    poke(10'd1, 4'd2);
    poke(10'd22, 4'd1);
    poke(10'd83, 4'd2);

    // drop while paused is ignored
    allow = 5'b00000; bomb_drop1 = 1'b1; tick(2);
    chk("paused_drop", bomb1_vis, 0);
    bomb_drop1 = 1'b0; allow = 5'b00010; tick(2);
    chk("paused_drop_after", bomb1_vis, 0);

    // basic bomb at tile 21: up brick, right steel
    bomb_drop1 = 1'b1; tick(1); bomb_drop1 = 1'b0;
    chk("armed_vis", bomb1_vis, 1);
    chk("bomb1X", bomb1X, 32);
    chk("bomb1Y", bomb1Y, 32);
    tick(119);
    chk("fuse_last_armed", bomb1_vis, 1);
    tick(1);
    chk("detonate", bomb1_vis, 0);
    tick(1);
    chk("scan_up_addr", map_rdaddr, 1);
    tick(8);
    chk("blast_c", die_addr[0], 21);
    chk("blast_up", die_addr[1], 1);
    chk("blast_down", die_addr[2], 41);
    chk("blast_left", die_addr[3], 20);
    chk("blast_right_steel", die_addr[4], 10'h3FF);
    chk("wr_cnt1", wr_cnt, 1);
    chk("wr_addr", wr_addr_last, 1);
    chk("wr_data", wr_data_last, 0);
    chk("mem1_cleared", mem[1], 0);
    chk("idle_rdaddr", map_rdaddr, 0);
    chk("idle_wren", map_wren, 0);
    tick(29);
    chk("blast_last", die_addr[0], 21);
    tick(1);
    chk("blast_over", die_addr[0], 10'h3FF);

    // pause of 50 frames mid-fuse
    tick(2);
    bomb_drop1 = 1'b1; tick(1); bomb_drop1 = 1'b0;
    tick(19);
    allow = 5'b00000; tick(50);
    allow = 5'b00010; tick(100);
    chk("pause_fuse_last", bomb1_vis, 1);
    tick(1);
    chk("pause_detonate", bomb1_vis, 0);
    tick(9);
    chk("pause_blast_up", die_addr[1], 1);
    chk("pause_blast_right", die_addr[4], 10'h3FF);
    tick(30);
    chk("pause_blast_over", die_addr[0], 10'h3FF);

    // held drop: one bomb only
    tick(2);
    bomb_drop1 = 1'b1; tick(1);
    chk("held_first", bomb1_vis, 1);
    tick(199);
    chk("held_no_redrop", bomb1_vis, 0);
    chk("held_die0", die_addr[0], 10'h3FF);
    bomb_drop1 = 1'b0; tick(3);
    chk("held_release", bomb1_vis, 0);
    bomb_drop1 = 1'b1; tick(1); bomb_drop1 = 1'b0;
    chk("new_edge", bomb1_vis, 1);
    tick(160);
    chk("new_edge_done", bomb1_vis, 0);
    chk("wr_cnt_steady", wr_cnt, 1);

    // simultaneous fuses right after reset: player1 first
    Reset = 1'b1; tick(1); Reset = 1'b0; tick(1);
    bomb_drop1 = 1'b1; bomb_drop2 = 1'b1; tick(1); bomb_drop1 = 1'b0; bomb_drop2 = 1'b0;
    chk("p2_vis", bomb2_vis, 1);
    chk("bomb2X", bomb2X, 96);
    chk("bomb2Y", bomb2Y, 96);
    tick(120);
    chk("both_det1", bomb1_vis, 0);
    chk("both_det2", bomb2_vis, 0);
    tick(1);
    chk("p1_first", map_rdaddr, 1);
    tick(7);
    chk("p1_right", map_rdaddr, 22);
    tick(1);
    chk("p2_next", map_rdaddr, 43);
    chk("p1_blast", die_addr[0], 21);
    chk("p2_not_blast", die_addr[5], 10'h3FF);
    tick(3);
    chk("p2_wren", map_wren, 1);
    chk("p2_wraddr", map_wraddr, 83);
    chk("p2_wrdata", map_wrdata, 0);
    tick(5);
    chk("p2_c", die_addr[5], 63);
    chk("p2_up", die_addr[6], 43);
    chk("p2_down", die_addr[7], 83);
    chk("p2_left", die_addr[8], 62);
    chk("p2_right", die_addr[9], 64);
    chk("wr_cnt2", wr_cnt, 2);
    tick(31);
    chk("both_over1", die_addr[0], 10'h3FF);
    chk("both_over2", die_addr[5], 10'h3FF);

    // reset in the middle of a scan
    poke(10'd20, 4'd2);
    bomb_drop1 = 1'b1; tick(1); bomb_drop1 = 1'b0;
    tick(122);
    chk("pre_reset_scan", map_rdaddr, 1);
    Reset = 1'b1; tick(1);
    chk("rst_scan_wren", map_wren, 0);
    chk("rst_scan_vis", bomb1_vis, 0);
    chk("rst_scan_bomb1X", bomb1X, 0);
    for (int i = 0; i < 10; i++) chk($sformatf("rst_scan_die%0d", i), die_addr[i], 10'h3FF);
    Reset = 1'b0; tick(10);
    chk("post_rst_wren", map_wren, 0);
    chk("post_rst_wr_cnt", wr_cnt, 2);
    chk("post_rst_mem20", mem[20], 2);
    chk("post_rst_die0", die_addr[0], 10'h3FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_sched.md
BOMB_SCHED -- requirements
Module: bomb_sched

Interface
REQ-001 Parameters SHALL be: FUSE_FRAMES, default 120, frames from drop to detonation; BLAST_FRAMES, default 30, frames the blast is lethal; TILE_IDLE, default 10'h3FF, value driven on an unused die_addr entry.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- frame_clk  in  1  sole clock.
- Reset  in  1  asynchronous, active-high.
- allow  in  5  game-phase code; values 00000, 00001 and 11111 mean paused.
- bomb_drop1, bomb_drop2  in  1  drop request, a level held while the key is down.
- user1X, user1Y, user2X, user2Y  in  10  player top-left pixel positions.
- map_rdaddr  out  10  map read tile index.
- map_rddata  in  4  map tile read data, 1-cycle latency.
- map_wraddr  out  10  map write tile index.
- map_wrdata  out  4  map write data.
- map_wren  out  1  map write strobe.
- bomb1X, bomb1Y, bomb2X, bomb2Y  out  10  bomb top-left pixel position.
- bomb1XS, bomb1YS, bomb2XS, bomb2YS  out  10  bomb size; constant 32.
- bomb1_vis, bomb2_vis  out  1  high in ARMED.
- die_addr  out  10x10  lethal tile indices.

Function
REQ-003 One independent slot per player SHALL exist, with states IDLE, ARMED, WAITMAP, SCAN and BLAST.
REQ-004 A drop SHALL be accepted only on the rising edge of bomb_dropN, only while the slot is IDLE and only when not paused; drops at any other time SHALL be ignored.
REQ-005 On acceptance, the latched tile SHALL be ((uY+13)>>5)*20 + ((uX+10)>>5).
- bombNX SHALL be col*32 and bombNY SHALL be row*32.
- The fuse counter SHALL load FUSE_FRAMES-1 and the slot SHALL enter ARMED on the next edge.
REQ-006 In ARMED, the fuse SHALL decrement once per unpaused frame and SHALL go WAITMAP after the cycle in which it reads 0; detonation occurs exactly FUSE_FRAMES unpaused cycles after acceptance.
REQ-007 The map port SHALL be shared round-robin between the two slots.
- If both slots enter WAITMAP in the same cycle, the slot that was not granted last SHALL win; player1 wins after reset.
- The loser SHALL wait in WAITMAP.
REQ-008 SCAN SHALL read the four arm tiles in order up (t-20), down (t+20), left (t-1), right (t+1), taking 2 cycles per arm: address, then data.
REQ-009 Per arm:
- data 3'b010 (brick): map_wren pulses for 1 cycle with map_wraddr equal to the arm tile and map_wrdata 0; the arm is lethal.
- data 3'b001 (steel): no write; the arm is not lethal.
- any other data: no write; the arm is lethal.
REQ-010 SCAN SHALL last exactly 8 cycles and SHALL then enter BLAST with the counter loaded to BLAST_FRAMES-1.
REQ-011 In BLAST, player1 SHALL drive die_addr[0..4] and player2 SHALL drive die_addr[5..9], in the order centre, up, down, left, right.
- Non-lethal arms SHALL read TILE_IDLE.
- All five entries SHALL read TILE_IDLE outside BLAST.
REQ-012 BLAST SHALL end after BLAST_FRAMES unpaused frames and return the slot to IDLE.
REQ-013 While paused, the fuse and blast counters and any WAITMAP slot SHALL hold. A SCAN already in progress SHALL run to completion so the map is never left half-updated.
REQ-014 When the grant is idle, map_wren SHALL be 0 and map_rdaddr SHALL be 0.
REQ-015 Both players MAY bomb the same tile. The scans SHALL serialise, and the second scan SHALL read the already-cleared map.
REQ-016 Arithmetic SHALL be 10-bit unsigned; arm indices are not range-checked, because centre tiles are never on the border.

Reset
REQ-017 Reset SHALL asynchronously force every slot to IDLE and clear all counters.
- Outputs after reset: all die_addr entries TILE_IDLE; bombN_vis 0; map_wren 0; bomb positions 0; round-robin pointer set so player1 wins first.
REQ-018 Reset asserted mid-SCAN SHALL abort with no further write; a write already issued stands.

Structure
REQ-019 A shared package SHALL hold the tile codes (BRICK 3'b010, STEEL 3'b001, EMPTY 0), MAP_COLS 20, TILE 32 and TILE_IDLE.
REQ-020 A sub-module bomb_slot (per-player FSM and counters) SHALL be instantiated twice; arbitration and the scan sequencer SHALL sit in bomb_sched.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Player1 at (39,35), pulse drop1 -> tile 21, bomb1X=32, bomb1Y=32; detonation 120 cycles later; die_addr[0]=21 for 30 cycles.
- Arms up=brick, right=steel, others empty -> exactly one write (addr 1, data 0); die_addr[4]=3FF; die_addr[1]=1.
- Both fuses expire in the same cycle -> player1 scans first, player2 scans immediately after; no overlapping reads.
- drop1 held high for 200 cycles -> exactly one bomb, no re-drop after BLAST until a new rising edge.
- allow=00000 for 50 cycles mid-fuse -> detonation delayed by exactly 50 cycles.
- Reset mid-SCAN -> map_wren 0 thereafter, all die_addr entries 3FF.
